// File: rtl/controle_pc.sv
// controle_pc: program counter and fetch sequencing.
//
// Holds the PC that addresses instruction memory and picks the next PC from
// the control unit's Desvio/TypeJR/Halt outputs and the comparator's Cond.
// An IN instruction (Halt=1) stalls the PC until the operator presses a
// debounced push-button. The stage then issues a one-cycle InCommit so the
// register file can take the input value, and fetch resumes at PC+1.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-low
//   Halt       current instruction is IN
//   Desvio     current instruction is jump / BEQ / BNE / JR
//   TypeJR     branch target comes from RegTarget
//   Cond       branch condition (driven to 1 upstream for unconditional jumps)
//   ImmTarget  immediate branch/jump target
//   RegTarget  register value for JR; the low ADDR_W bits are used
//   Confirm    raw asynchronous push-button, active-high
//   PC         current instruction address
//   WriteEn    register-write qualifier, ANDed with RegWrite
//   InCommit   one-cycle pulse while the IN data is written
//   Waiting    high while stalled for input
module controle_pc #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Halt,
    input  logic              Desvio,
    input  logic              TypeJR,
    input  logic              Cond,
    input  logic [ADDR_W-1:0] ImmTarget,
    input  logic [DATA_W-1:0] RegTarget,
    input  logic              Confirm,
    output logic [ADDR_W-1:0] PC,
    output logic              WriteEn,
    output logic              InCommit,
    output logic              Waiting
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_IN = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;

    logic [1:0]        sync;
    logic [CNT_W-1:0]  cnt;
    logic              stable;
    logic              deb_done;
    logic              press;

    // Only the low ADDR_W bits of the JR source address instruction memory.
    logic unused_regtarget;
    assign unused_regtarget = ^RegTarget[DATA_W-1:ADDR_W];

    // ---------------- button conditioning ----------------
    assign deb_done = (cnt == CNT_W'(DEB_CYCLES - 1));
    // Press is the cycle on which the stable flag flips 0->1. A held button
    // cannot fire again until a debounced release returns stable to 0.
    assign press    = sync[1] & ~stable & deb_done;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], Confirm};
            if (sync[1] != stable) begin
                if (deb_done) begin
                    stable <= ~stable;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // ---------------- fetch state machine ----------------
    assign pc_inc = PC + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        WriteEn = 1'b0;
        case (state_q)
            RUN: begin
                if (Halt) begin
                    // Halt wins over a simultaneous Desvio.
                    state_d = WAIT_IN;
                end else begin
                    WriteEn = 1'b1;
                    if (Desvio && (TypeJR || Cond))
                        pc_d = TypeJR ? RegTarget[ADDR_W-1:0] : ImmTarget;
                    else
                        pc_d = pc_inc;
                end
            end
            WAIT_IN: begin
                // Only a press seen while already waiting releases the stall.
                if (press)
                    state_d = COMMIT;
            end
            COMMIT: begin
                WriteEn = 1'b1;
                pc_d    = pc_inc;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            PC      <= RESET_PC;
        end else begin
            state_q <= state_d;
            PC      <= pc_d;
        end
    end

    // Both are straight decodes of the state register, so they are glitch-free.
    assign Waiting  = (state_q == WAIT_IN);
    assign InCommit = (state_q == COMMIT);

endmodule

// File: tb/tb_controle_pc.sv
module tb_controle_pc;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEB    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              Halt, Desvio, TypeJR, Cond, Confirm;
    logic [ADDR_W-1:0] ImmTarget;
    logic [DATA_W-1:0] RegTarget;
    logic [ADDR_W-1:0] PC;
    logic              WriteEn, InCommit, Waiting;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              wt;
        logic              ic;
        string             tag;
    } exp_t;

    exp_t sb[$];

    controle_pc #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0), .DEB_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .Halt(Halt), .Desvio(Desvio),
        .TypeJR(TypeJR), .Cond(Cond), .ImmTarget(ImmTarget),
        .RegTarget(RegTarget), .Confirm(Confirm), .PC(PC),
        .WriteEn(WriteEn), .InCommit(InCommit), .Waiting(Waiting)
    );

    always #5 clock = ~clock;

    // One clock step: WriteEn is checked against the inputs now applied,
    // the expected registered outputs are queued and compared after the edge.
    task automatic step(input logic [ADDR_W-1:0] pc, input logic wt,
                        input logic ic, input logic chk_we, input logic we,
                        input string tag);
        exp_t e;
        #1;
        if (chk_we) begin
            checks++;
            assert (WriteEn === we) else begin
                errors++;
                $error("FAIL %s.WriteEn got %b expected %b", tag, WriteEn, we);
            end
        end
        e.pc = pc; e.wt = wt; e.ic = ic; e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        assert (PC === e.pc) else begin
            errors++;
            $error("FAIL %s.PC got %0h expected %0h", e.tag, PC, e.pc);
        end
        checks++;
        assert (Waiting === e.wt) else begin
            errors++;
            $error("FAIL %s.Waiting got %b expected %b", e.tag, Waiting, e.wt);
        end
        checks++;
        assert (InCommit === e.ic) else begin
            errors++;
            $error("FAIL %s.InCommit got %b expected %b", e.tag, InCommit, e.ic);
        end
    endtask

    initial begin
        reset = 1'b0; Halt = 1'b0; Desvio = 1'b0; TypeJR = 1'b0; Cond = 1'b0;
        Confirm = 1'b0; ImmTarget = '0; RegTarget = '0;

        // reset held two cycles
        step(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, "rst0");
        step(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, "rst1");

        // sequential fetch
        reset = 1'b1;
        for (int i = 1; i <= 5; i++)
            step(ADDR_W'(i), 1'b0, 1'b0, 1'b1, 1'b1, "seq");

        // branch select
        Desvio = 1'b1; Cond = 1'b1; ImmTarget = 10'h02A;
        step(10'h02A, 1'b0, 1'b0, 1'b1, 1'b1, "br_taken");
        Cond = 1'b0;
        step(10'h02B, 1'b0, 1'b0, 1'b1, 1'b1, "br_not_taken");
        TypeJR = 1'b1; RegTarget = 32'hFFFF_F123;
        step(10'h123, 1'b0, 1'b0, 1'b1, 1'b1, "jr_trunc");

        // wrap
        TypeJR = 1'b0; Cond = 1'b1; ImmTarget = 10'h3FF;
        step(10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, "jmp_3ff");
        Desvio = 1'b0;
        step(10'h000, 1'b0, 1'b0, 1'b1, 1'b1, "wrap");

        // IN stall at PC=7
        Desvio = 1'b1; ImmTarget = 10'h007;
        step(10'h007, 1'b0, 1'b0, 1'b1, 1'b1, "jmp_7");
        Desvio = 1'b0; Halt = 1'b1;
        step(10'h007, 1'b1, 1'b0, 1'b1, 1'b0, "halt_enter");

        // a 3-cycle bounce must not be accepted
        Confirm = 1'b1;
        for (int i = 0; i < 3; i++)
            step(10'h007, 1'b1, 1'b0, 1'b1, 1'b0, "short_press");
        Confirm = 1'b0;
        for (int i = 0; i < 8; i++)
            step(10'h007, 1'b1, 1'b0, 1'b1, 1'b0, "short_release");

        // real press: 2 sync cycles + DEB stable samples, then one commit
        Confirm = 1'b1;
        for (int i = 0; i < DEB + 1; i++)
            step(10'h007, 1'b1, 1'b0, 1'b1, 1'b0, "press_wait");
        step(10'h007, 1'b0, 1'b1, 1'b1, 1'b0, "press_commit");
        step(10'h008, 1'b0, 1'b0, 1'b1, 1'b1, "after_commit");

        // second IN with the button still held: no new event
        step(10'h008, 1'b1, 1'b0, 1'b1, 1'b0, "in2_enter");
        for (int i = 0; i < DEB + 4; i++)
            step(10'h008, 1'b1, 1'b0, 1'b1, 1'b0, "held");
        Confirm = 1'b0;
        for (int i = 0; i < DEB + 4; i++)
            step(10'h008, 1'b1, 1'b0, 1'b1, 1'b0, "release");
        Confirm = 1'b1;
        for (int i = 0; i < DEB + 1; i++)
            step(10'h008, 1'b1, 1'b0, 1'b1, 1'b0, "repress_wait");
        step(10'h008, 1'b0, 1'b1, 1'b1, 1'b0, "repress_commit");
        Halt = 1'b0;
        step(10'h009, 1'b0, 1'b0, 1'b1, 1'b1, "after_commit2");

        // Halt has priority over Desvio
        Halt = 1'b1; Desvio = 1'b1; Cond = 1'b1; ImmTarget = 10'h055;
        step(10'h009, 1'b1, 1'b0, 1'b1, 1'b0, "prio");
        Confirm = 1'b0;
        step(10'h009, 1'b1, 1'b0, 1'b1, 1'b0, "prio_hold");

        // reset mid-stall abandons the IN
        reset = 1'b0;
        step(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
        reset = 1'b1; Halt = 1'b0; Desvio = 1'b0;
        step(10'h001, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst1");
        step(10'h002, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
